// File: rtl/rgb_byte_serializer.sv
// rgb_byte_serializer: takes one 24-bit RGB pixel through a valid/ready
// handshake and emits it as three bytes on a valid/ready byte stream,
// with data_out_last marking the third byte of each pixel.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both 1. The producer holds valid and its data
// stable until that transfer. The byte side never drops valid or changes
// data while data_out_ready is low.
module rgb_byte_serializer #(
  parameter int BGR_ORDER = 0  // 0: R,G,B   1: B,G,R
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       pixel_in_valid,
  input  logic [7:0] r_data_in,
  input  logic [7:0] g_data_in,
  input  logic [7:0] b_data_in,
  output logic       pixel_in_ready,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  output logic       data_out_last,
  input  logic       data_out_ready,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    BYTE2 = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] r_q, g_q, b_q;
  logic [7:0] first_byte, third_byte;
  logic       pixel_accept;

  // Byte order is fixed at elaboration; the middle byte is always green.
  assign first_byte = (BGR_ORDER != 0) ? b_q : r_q;
  assign third_byte = (BGR_ORDER != 0) ? r_q : b_q;

  assign pixel_accept = pixel_in_valid & pixel_in_ready;
  assign dbg_state_o  = state_q;

  // State register; reset discards any pixel that is mid-serialization.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pixel registers load only on an accept edge, so a new pixel can never
  // disturb the bytes of the one still being emitted.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_q <= 8'd0;
      g_q <= 8'd0;
      b_q <= 8'd0;
    end else if (pixel_accept) begin
      r_q <= r_data_in;
      g_q <= g_data_in;
      b_q <= b_data_in;
    end
  end

  // Next-state and output decode. In BYTE2 the block is ready for a new
  // pixel in the same cycle the last byte leaves, which gives gap-free
  // back-to-back pixels (ready depends combinationally on data_out_ready).
  always_comb begin
    state_d        = state_q;
    pixel_in_ready = 1'b0;
    data_out_valid = 1'b0;
    data_out_last  = 1'b0;
    data_out       = 8'd0;
    case (state_q)
      IDLE: begin
        pixel_in_ready = 1'b1;
        if (pixel_in_valid) begin
          state_d = BYTE0;
        end
      end
      BYTE0: begin
        data_out_valid = 1'b1;
        data_out       = first_byte;
        if (data_out_ready) begin
          state_d = BYTE1;
        end
      end
      BYTE1: begin
        data_out_valid = 1'b1;
        data_out       = g_q;
        if (data_out_ready) begin
          state_d = BYTE2;
        end
      end
      BYTE2: begin
        data_out_valid = 1'b1;
        data_out_last  = 1'b1;
        data_out       = third_byte;
        pixel_in_ready = data_out_ready;
        if (data_out_ready) begin
          state_d = pixel_in_valid ? BYTE0 : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rgb_byte_serializer.sv
// Bench for rgb_byte_serializer: two instances (RGB and BGR order) share
// the same stimulus and are checked every cycle against a byte-queue model.
module tb_rgb_byte_serializer;

  logic       clk;
  logic       rst;
  logic       pix_valid;
  logic [7:0] r_in, g_in, b_in;
  logic       dready;

  logic       rdy0, vld0, last0;
  logic [7:0] dout0;
  logic [1:0] st0;
  logic       rdy1, vld1, last1;
  logic [7:0] dout1;
  logic [1:0] st1;

  int checks = 0;
  int errors = 0;

  // expected byte streams still owed by each instance
  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rgb_byte_serializer #(.BGR_ORDER(0)) dut_rgb (
    .sys_clk(clk), .sys_rst(rst), .pixel_in_valid(pix_valid),
    .r_data_in(r_in), .g_data_in(g_in), .b_data_in(b_in),
    .pixel_in_ready(rdy0), .data_out(dout0), .data_out_valid(vld0),
    .data_out_last(last0), .data_out_ready(dready), .dbg_state_o(st0)
  );

  rgb_byte_serializer #(.BGR_ORDER(1)) dut_bgr (
    .sys_clk(clk), .sys_rst(rst), .pixel_in_valid(pix_valid),
    .r_data_in(r_in), .g_data_in(g_in), .b_data_in(b_in),
    .pixel_in_ready(rdy1), .data_out(dout1), .data_out_valid(vld1),
    .data_out_last(last1), .data_out_ready(dready), .dbg_state_o(st1)
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic       rdy;
    logic       vld;
    logic       last0;
    logic       last1;
    logic [7:0] d0;
    logic [7:0] d1;
  } obs_t;

  // One clock cycle: drive inputs after the falling edge, compare outputs
  // against the byte-queue model, then advance the model across the edge.
  task automatic step(input logic v, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input logic dr, input logic rs,
                      output logic acc, output obs_t obs);
    int         n;
    logic       e_rdy;
    @(negedge clk);
    pix_valid = v; r_in = r; g_in = g; b_in = b; dready = dr; rst = rs;
    #1;
    n     = exp0_q.size();
    e_rdy = (n == 0) || (n == 1 && dr);
    chk("ready_rgb", {7'd0, rdy0}, {7'd0, e_rdy});
    chk("ready_bgr", {7'd0, rdy1}, {7'd0, e_rdy});
    chk("valid_rgb", {7'd0, vld0}, {7'd0, n > 0});
    chk("valid_bgr", {7'd0, vld1}, {7'd0, n > 0});
    chk("last_rgb",  {7'd0, last0}, {7'd0, n == 1});
    chk("last_bgr",  {7'd0, last1}, {7'd0, n == 1});
    chk("data_rgb",  dout0, (n > 0) ? exp0_q[0] : 8'd0);
    chk("data_bgr",  dout1, (n > 0) ? exp1_q[0] : 8'd0);
    obs = '{rdy: rdy0, vld: vld0, last0: last0, last1: last1, d0: dout0, d1: dout1};
    acc = !rs && v && e_rdy;
    if (rs) begin
      exp0_q.delete();
      exp1_q.delete();
    end else begin
      if (n > 0 && dr) begin
        void'(exp0_q.pop_front());
        void'(exp1_q.pop_front());
      end
      if (acc) begin
        exp0_q.push_back(r); exp0_q.push_back(g); exp0_q.push_back(b);
        exp1_q.push_back(b); exp1_q.push_back(g); exp1_q.push_back(r);
      end
    end
    @(posedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       v;
    logic [7:0] r, g, b;
    logic       dr;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_d0;
    logic [7:0] e_d1;
    logic       e_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic acc;
    obs_t obs;
    logic [7:0] pr, pg, pb;
    logic       have_pix;
    int         rdy_pulses;
    int         acc_cycle;

    pix_valid = 1'b0; r_in = 8'd0; g_in = 8'd0; b_in = 8'd0;
    dready = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    // last reset cycle doubles as the reset-state check
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, acc, obs);

    // single pixel 11/22/33, both orders
    vecs[0] = '{1'b1, 8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 8'h33, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 8'h22, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 8'h11, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].v, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].dr, 1'b0, acc, obs);
      chk($sformatf("tbl%0d_ready", i), {7'd0, obs.rdy}, {7'd0, vecs[i].e_rdy});
      chk($sformatf("tbl%0d_valid", i), {7'd0, obs.vld}, {7'd0, vecs[i].e_vld});
      chk($sformatf("tbl%0d_rgb", i), obs.d0, vecs[i].e_d0);
      chk($sformatf("tbl%0d_bgr", i), obs.d1, vecs[i].e_d1);
      chk($sformatf("tbl%0d_last", i), {7'd0, obs.last0 & obs.last1}, {7'd0, vecs[i].e_last});
    end

    // 4 back-to-back pixels: 12 bytes, ready pulsing every 3rd cycle
    rdy_pulses = 0;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 3; c++) begin
        step(1'b1, 8'(8'h40 + p), 8'(8'h50 + p), 8'(8'h60 + p), 1'b1, 1'b0, acc, obs);
        if (obs.rdy) rdy_pulses++;
        if (p > 0 || c > 0) chk("b2b_valid", {7'd0, obs.vld}, 8'd1);
        if (c == 0) chk("b2b_ready_phase", {7'd0, obs.rdy}, 8'd1);
      end
    end
    chk("b2b_ready_pulses", 8'(rdy_pulses), 8'd4);
    for (int c = 0; c < 3; c++) step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, acc, obs);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, acc, obs);

    // stall 5 cycles in BYTE1
    step(1'b1, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, acc, obs);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, acc, obs);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 8'hE0, 8'hE1, 8'hE2, 1'b0, 1'b0, acc, obs);
      chk("stall_data", obs.d0, 8'h22);
      chk("stall_ready", {7'd0, obs.rdy}, 8'd0);
    end
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, acc, obs);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, acc, obs);
    chk("stall_resume", obs.d0, 8'h33);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, acc, obs);

    // reset asserted in BYTE1, then pixel AA/BB/CC
    step(1'b1, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, acc, obs);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, acc, obs);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, acc, obs);
    step(1'b1, 8'hAA, 8'hBB, 8'hCC, 1'b1, 1'b0, acc, obs);
    chk("rst_valid", {7'd0, obs.vld}, 8'd0);
    chk("rst_data", obs.d0, 8'h00);
    chk("rst_ready", {7'd0, obs.rdy}, 8'd1);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, acc, obs);
    chk("post_rst_b0", obs.d0, 8'hAA);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, acc, obs);
    chk("post_rst_b1", obs.d0, 8'hBB);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, acc, obs);
    chk("post_rst_b2", obs.d0, 8'hCC);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, acc, obs);

    // valid with changing inputs during emission: accepted only at BYTE2
    step(1'b1, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, acc, obs);
    acc_cycle = -1;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 8'($urandom_range(255)), 8'($urandom_range(255)),
           8'($urandom_range(255)), 1'b1, 1'b0, acc, obs);
      if (acc && acc_cycle < 0) acc_cycle = c;
    end
    chk("inflight_accept_cycle", 8'(acc_cycle), 8'd2);
    for (int c = 0; c < 4; c++) step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, acc, obs);

    // randomized traffic; upstream holds each pixel until accepted
    have_pix = 1'b0;
    pr = 8'd0; pg = 8'd0; pb = 8'd0;
    for (int c = 0; c < 600; c++) begin
      logic v;
      if (!have_pix) begin
        pr = 8'($urandom_range(255));
        pg = 8'($urandom_range(255));
        pb = 8'($urandom_range(255));
      end
      v = have_pix || ($urandom_range(3) != 0);
      have_pix = v;
      step(v, pr, pg, pb, ($urandom_range(3) != 0), ($urandom_range(60) == 0), acc, obs);
      if (acc) have_pix = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_byte_serializer.md
RGB_BYTE_SERIALIZER -- requirements
Module: rgb_byte_serializer

Interface
REQ-001 SHALL have parameter: BGR_ORDER, default 0, emission order: 0 = R,G,B; 1 = B,G,R.
REQ-002 SHALL have port: sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: sys_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: pixel_in_valid  input  1  upstream pixel present.
REQ-005 SHALL have port: r_data_in  input  8  red component.
REQ-006 SHALL have port: g_data_in  input  8  green component.
REQ-007 SHALL have port: b_data_in  input  8  blue component.
REQ-008 SHALL have port: pixel_in_ready  output  1  block can accept a pixel this cycle.
REQ-009 SHALL have port: data_out  output  8  serialized byte.
REQ-010 SHALL have port: data_out_valid  output  1  data_out holds a valid byte.
REQ-011 SHALL have port: data_out_last  output  1  data_out is the third byte of its pixel.
REQ-012 SHALL have port: data_out_ready  input  1  downstream accepts the byte this cycle.

Function
REQ-013 SHALL accept a pixel only on a cycle with pixel_in_valid=1 and pixel_in_ready=1, capturing r/g/b into internal registers on that edge.
REQ-014 SHALL transfer a byte only on a cycle with data_out_valid=1 and data_out_ready=1.
REQ-015 SHALL implement FSM states IDLE, BYTE0, BYTE1, BYTE2, with IDLE entered on reset.
REQ-016 SHALL transition IDLE->BYTE0 on pixel accept, and otherwise remain in IDLE.
REQ-017 SHALL transition BYTE0->BYTE1 and BYTE1->BYTE2 on byte transfer, and otherwise hold state.
REQ-018 SHALL, in BYTE2 on byte transfer, go to BYTE0 if a new pixel is accepted in the same cycle, and otherwise go to IDLE.
REQ-019 SHALL drive pixel_in_ready = (state==IDLE) OR (state==BYTE2 AND data_out_ready); this combinational path from data_out_ready is permitted.
REQ-020 SHALL drive data_out_valid=1 in BYTE0/BYTE1/BYTE2 and 0 in IDLE.
REQ-021 SHALL, with BGR_ORDER=0, output data_out = R in BYTE0, G in BYTE1, B in BYTE2; with BGR_ORDER=1, output B, G, R respectively.
REQ-022 SHALL drive data_out_last=1 only in BYTE2, and 0 otherwise.
REQ-023 SHALL hold data_out, data_out_valid and data_out_last stable while data_out_valid=1 and data_out_ready=0.
REQ-024 SHALL not let a newly accepted pixel modify the bytes of a pixel still being emitted; the registers update only at the accept edge.
REQ-025 SHALL have a latency of 1 cycle from pixel accept to its first byte on data_out.
REQ-026 SHALL sustain back-to-back pixels with data_out_ready held at 1 at 3 bytes per 3 cycles, with no bubble.
REQ-027 SHALL ignore r/g/b_data_in values on cycles without an accept.
REQ-028 SHALL ignore pixel_in_valid while pixel_in_ready=0; upstream must hold its pixel until accepted.
REQ-029 SHALL drive data_out=8'd0 while in IDLE.

Reset
REQ-030 SHALL, on sys_rst=1 at a clock edge, set state=IDLE, clear the pixel registers to 0, and drive data_out=0, data_out_valid=0, data_out_last=0.
REQ-031 SHALL have sys_rst take priority over all other inputs; a pixel mid-serialization is discarded, with no partial bytes after reset.
REQ-032 SHALL drive pixel_in_ready=1 on the first cycle after reset is released.

Verification
REQ-033 SHALL cover: single pixel R=0x11,G=0x22,B=0x33 with BGR_ORDER=0 and ready=1 -> bytes 0x11,0x22,0x33 on 3 consecutive cycles, last=1 only on 0x33, then valid=0.
REQ-034 SHALL cover: same pixel with BGR_ORDER=1 -> bytes 0x33,0x22,0x11, last on 0x11.
REQ-035 SHALL cover: 4 back-to-back pixels with pixel_in_valid=1 and ready=1 -> 12 bytes with no gaps, pixel_in_ready pulsing on every 3rd cycle.
REQ-036 SHALL cover: data_out_ready=0 for 5 cycles during BYTE1 -> data_out stays 0x22 with valid=1, pixel_in_ready=0, then resumes with 0x33.
REQ-037 SHALL cover: sys_rst=1 asserted in BYTE1 -> next cycle valid=0, data_out=0, pixel_in_ready=1; the following pixel 0xAA,0xBB,0xCC serializes correctly.
REQ-038 SHALL cover: pixel_in_valid=1 while in BYTE1 with changing r/g/b inputs -> in-flight bytes unchanged, and the new pixel is accepted only at BYTE2 transfer.
